// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receive path.
//   UART_DATA_BITS  : default number of data bits per frame
//   UART_OVERSAMPLE : default number of Bclk ticks per bit period
//   rx_state_t      : receiver FSM state encoding
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2 -- two-flop synchronizer for a single asynchronous input.
//   clk     : system clock
//   reset_n : synchronous active-low reset, both flops reset to 1 (line idle)
//   d       : asynchronous input
//   q       : synchronized output
module uart_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver with optional parity and a one-deep
// output register with valid/ready handshake.
//   clk         : system clock
//   reset_n     : synchronous active-low reset
//   Bclk        : one-clk oversample tick, OVERSAMPLE x baud
//   rx          : asynchronous serial line, idle high
//   parity_en   : append a parity bit after the data bits
//   parity_odd  : 1 = odd parity, 0 = even parity
//   rx_data     : last accepted frame
//   rx_valid    : rx_data holds an unconsumed frame
//   rx_ready    : consumer accept (transfer on rx_valid & rx_ready)
//   frame_err   : one-clk pulse, stop bit sampled low
//   parity_err  : one-clk pulse, parity mismatch with good stop bit
//   overrun_err : one-clk pulse, good frame dropped because rx_data was full
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | line idle, waiting for rx low on a tick
// ST_START  | counting to mid start bit to confirm it
// ST_DATA   | sampling data bits LSB-first, one per bit period
// ST_PARITY | sampling and checking the parity bit
// ST_STOP   | sampling the stop bit and retiring the frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 Bclk,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    rx_state_t            state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 par_fail;
    logic                 rx_s;
    logic                 start_mid;
    logic                 bit_mid;
    logic                 handshake;

    uart_sync2 u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    assign start_mid = (tick_cnt == TICK_MID);
    assign bit_mid   = (tick_cnt == TICK_LAST);
    assign handshake = rx_valid & rx_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            par_fail    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;

            // A reload from ST_STOP below overrides this clear.
            if (handshake) begin
                rx_valid <= 1'b0;
            end

            if (Bclk) begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state     <= ST_START;
                            tick_cnt  <= '0;
                            bit_cnt   <= '0;
                            par_en_q  <= parity_en;
                            par_odd_q <= parity_odd;
                            par_fail  <= 1'b0;
                        end
                    end

                    ST_START: begin
                        if (start_mid) begin
                            tick_cnt <= '0;
                            state    <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    ST_DATA: begin
                        if (bit_mid) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                state   <= par_en_q ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    ST_PARITY: begin
                        if (bit_mid) begin
                            tick_cnt <= '0;
                            par_fail <= (rx_s != ((^shreg) ^ par_odd_q));
                            state    <= ST_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    ST_STOP: begin
                        if (bit_mid) begin
                            tick_cnt <= '0;
                            state    <= ST_IDLE;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                            end else if (par_fail) begin
                                parity_err <= 1'b1;
                            end else if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state    <= ST_IDLE;
                        tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       Bclk = 1'b0;
    logic       rx = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;

    int checks = 0;
    int errors = 0;

    int div = 27;
    int bdiv_cnt = 0;

    int n_fe = 0;
    int n_pe = 0;
    int n_oe = 0;

    bit         model_valid = 1'b0;
    logic [7:0] model_data = 8'h00;

    uart_rx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .Bclk        (Bclk),
        .rx          (rx),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bdiv_cnt >= div - 1) begin
            bdiv_cnt <= 0;
            Bclk     <= 1'b1;
        end else begin
            bdiv_cnt <= bdiv_cnt + 1;
            Bclk     <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (frame_err)   n_fe++;
        if (parity_err)  n_pe++;
        if (overrun_err) n_oe++;
    end

    // Reference outcome of one frame, from the frame-level rules: a low stop
    // bit is a framing error, else a bad parity bit is a parity error, else
    // the byte lands if the holding register is free or is dropped as overrun.
    function automatic void predict(input logic [7:0] d, input bit pen, input bit bad_par,
                                    input bit stop_bit, output int fe, output int pe,
                                    output int oe);
        fe = 0; pe = 0; oe = 0;
        if (!stop_bit)               fe = 1;
        else if (pen && bad_par)     pe = 1;
        else if (model_valid)        oe = 1;
        else begin
            model_valid = 1'b1;
            model_data  = d;
        end
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame plus one idle bit period. With scramble set, the parity
    // inputs are randomised from mid start bit to the end of the frame.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd,
                              input bit bad_par, input bit stop_bit, input bit scramble);
        int   bc;
        logic pbit;
        bc   = 16 * div;
        pbit = (^d) ^ podd ^ bad_par;
        @(negedge clk);
        parity_en  = pen;
        parity_odd = podd;
        rx         = 1'b0;
        wait_clks(bc / 2);
        if (scramble) begin
            parity_en  = 1'($urandom);
            parity_odd = 1'($urandom);
        end
        wait_clks(bc - bc / 2);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(bc);
        end
        if (pen) begin
            rx = pbit;
            wait_clks(bc);
        end
        rx = stop_bit;
        wait_clks(bc);
        rx         = 1'b1;
        parity_en  = pen;
        parity_odd = podd;
        wait_clks(bc);
    endtask

    task automatic do_handshake(input string name);
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== model_data) begin
            errors++;
            $display("FAIL %s_hs_pre: rx_valid=%0b rx_data=%02h expected valid=1 data=%02h",
                     name, rx_valid, rx_data, model_data);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_hs_clear: rx_valid=%0b expected 0", name, rx_valid);
        end
        model_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_clks(5);
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: rx_valid=%0b rx_data=%02h expected 0/00", rx_valid, rx_data);
        end
        checks++;
        if ({frame_err, parity_err, overrun_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_err: errs=%03b expected 000",
                     {frame_err, parity_err, overrun_err});
        end
        reset_n = 1'b1;
        wait_clks(20);
    endtask

    task automatic test_basic_8n1();
        int fe0, pe0, oe0, efe, epe, eoe;
        div = 27;
        wait_clks(30);
        fe0 = n_fe; pe0 = n_pe; oe0 = n_oe;
        predict(8'hA5, 1'b0, 1'b0, 1'b1, efe, epe, eoe);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL a5_data: rx_valid=%0b rx_data=%02h expected 1/a5", rx_valid, rx_data);
        end
        checks++;
        if (n_fe - fe0 != efe || n_pe - pe0 != epe || n_oe - oe0 != eoe) begin
            errors++;
            $display("FAIL a5_errs: fe=%0d pe=%0d oe=%0d expected 0 0 0",
                     n_fe - fe0, n_pe - pe0, n_oe - oe0);
        end
        do_handshake("a5");
        div = 4;
        wait_clks(10);
    endtask

    task automatic test_parity();
        int fe0, pe0, oe0, efe, epe, eoe;
        predict(8'h3C, 1'b1, 1'b0, 1'b1, efe, epe, eoe);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL par_good: rx_valid=%0b rx_data=%02h expected 1/3c", rx_valid, rx_data);
        end
        do_handshake("par_good");
        fe0 = n_fe; pe0 = n_pe; oe0 = n_oe;
        predict(8'h3C, 1'b1, 1'b1, 1'b1, efe, epe, eoe);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (n_pe - pe0 != 1 || n_fe - fe0 != 0 || n_oe - oe0 != 0) begin
            errors++;
            $display("FAIL par_bad_pulse: pe=%0d fe=%0d oe=%0d expected 1 0 0",
                     n_pe - pe0, n_fe - fe0, n_oe - oe0);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL par_bad_valid: rx_valid=%0b expected 0", rx_valid);
        end
    endtask

    task automatic test_false_start();
        int fe0, pe0, oe0;
        fe0 = n_fe; pe0 = n_pe; oe0 = n_oe;
        @(negedge clk);
        rx = 1'b0;
        wait_clks(4 * div);
        rx = 1'b1;
        wait_clks(3 * 16 * div);
        checks++;
        if (rx_valid !== 1'b0 || n_fe != fe0 || n_pe != pe0 || n_oe != oe0) begin
            errors++;
            $display("FAIL false_start: rx_valid=%0b fe=%0d pe=%0d oe=%0d expected 0 0 0 0",
                     rx_valid, n_fe - fe0, n_pe - pe0, n_oe - oe0);
        end
    endtask

    task automatic test_frame_err();
        int fe0, pe0, oe0, efe, epe, eoe;
        fe0 = n_fe; pe0 = n_pe; oe0 = n_oe;
        predict(8'h55, 1'b0, 1'b0, 1'b0, efe, epe, eoe);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_clks(2 * 16 * div);
        checks++;
        if (n_fe - fe0 != 1 || n_pe != pe0 || n_oe != oe0) begin
            errors++;
            $display("FAIL frame_err_pulse: fe=%0d pe=%0d oe=%0d expected 1 0 0",
                     n_fe - fe0, n_pe - pe0, n_oe - oe0);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_valid: rx_valid=%0b expected 0", rx_valid);
        end
        predict(8'h12, 1'b0, 1'b0, 1'b1, efe, epe, eoe);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h12) begin
            errors++;
            $display("FAIL after_fe_data: rx_valid=%0b rx_data=%02h expected 1/12", rx_valid, rx_data);
        end
        do_handshake("after_fe");
    endtask

    task automatic test_overrun();
        int fe0, pe0, oe0, efe, epe, eoe;
        fe0 = n_fe; pe0 = n_pe; oe0 = n_oe;
        predict(8'h11, 1'b0, 1'b0, 1'b1, efe, epe, eoe);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        predict(8'h22, 1'b0, 1'b0, 1'b1, efe, epe, eoe);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            errors++;
            $display("FAIL overrun_hold: rx_valid=%0b rx_data=%02h expected 1/11", rx_valid, rx_data);
        end
        checks++;
        if (n_oe - oe0 != 1 || n_fe != fe0 || n_pe != pe0) begin
            errors++;
            $display("FAIL overrun_pulse: oe=%0d fe=%0d pe=%0d expected 1 0 0",
                     n_oe - oe0, n_fe - fe0, n_pe - pe0);
        end
        do_handshake("overrun");
    endtask

    task automatic test_reset_midframe();
        int fe0, pe0, oe0, efe, epe, eoe, bc;
        bc = 16 * div;
        predict(8'h5A, 1'b0, 1'b0, 1'b1, efe, epe, eoe);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        fe0 = n_fe; pe0 = n_pe; oe0 = n_oe;
        @(negedge clk);
        rx = 1'b0;
        wait_clks(bc);
        rx = 1'b1;
        wait_clks(3 * bc + bc / 2);
        reset_n = 1'b0;
        wait_clks(3);
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 ||
            {frame_err, parity_err, overrun_err} !== 3'b000) begin
            errors++;
            $display("FAIL midframe_reset: rx_valid=%0b rx_data=%02h errs=%03b expected 0/00/000",
                     rx_valid, rx_data, {frame_err, parity_err, overrun_err});
        end
        reset_n = 1'b1;
        model_valid = 1'b0;
        wait_clks(6 * bc);
        checks++;
        if (rx_valid !== 1'b0 || n_fe != fe0 || n_pe != pe0 || n_oe != oe0) begin
            errors++;
            $display("FAIL midframe_quiet: rx_valid=%0b fe=%0d pe=%0d oe=%0d expected 0 0 0 0",
                     rx_valid, n_fe - fe0, n_pe - pe0, n_oe - oe0);
        end
        predict(8'h81, 1'b0, 1'b0, 1'b1, efe, epe, eoe);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin
            errors++;
            $display("FAIL after_reset_data: rx_valid=%0b rx_data=%02h expected 1/81", rx_valid, rx_data);
        end
        do_handshake("after_reset");
    endtask

    task automatic test_random();
        int         fe0, pe0, oe0, efe, epe, eoe;
        logic [7:0] d;
        bit         pen, podd, bad_par, stop_bit;
        for (int n = 0; n < 24; n++) begin
            if (model_valid && ($urandom_range(2, 0) != 0)) do_handshake("rand");
            d        = 8'($urandom);
            pen      = 1'($urandom);
            podd     = 1'($urandom);
            bad_par  = pen && ($urandom_range(4, 0) == 0);
            stop_bit = ($urandom_range(5, 0) != 0);
            fe0 = n_fe; pe0 = n_pe; oe0 = n_oe;
            predict(d, pen, bad_par, stop_bit, efe, epe, eoe);
            send_frame(d, pen, podd, bad_par, stop_bit, 1'b1);
            if (!stop_bit) wait_clks(2 * 16 * div);
            checks++;
            if (n_fe - fe0 != efe || n_pe - pe0 != epe || n_oe - oe0 != eoe) begin
                errors++;
                $display("FAIL rand%0d_errs: fe=%0d pe=%0d oe=%0d expected %0d %0d %0d (d=%02h pen=%0b odd=%0b)",
                         n, n_fe - fe0, n_pe - pe0, n_oe - oe0, efe, epe, eoe, d, pen, podd);
            end
            checks++;
            if (rx_valid !== model_valid || (model_valid && rx_data !== model_data)) begin
                errors++;
                $display("FAIL rand%0d_data: rx_valid=%0b rx_data=%02h expected %0b/%02h",
                         n, rx_valid, rx_data, model_valid, model_data);
            end
        end
        if (model_valid) do_handshake("rand_end");
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the number of data bits per frame (legal 5..8).
REQ-002 Parameter OVERSAMPLE, default 16, SHALL set the number of Bclk ticks per bit period.
REQ-003 clk  input  1  SHALL be the single system clock; all logic is on its rising edge.
REQ-004 reset_n  input  1  SHALL be a synchronous, active-low reset.
REQ-005 Bclk  input  1  SHALL be a one-clk-wide oversample tick from the baud generator, at OVERSAMPLE x baud.
REQ-006 rx  input  1  SHALL be the asynchronous serial line, idle high.
REQ-007 parity_en  input  1  SHALL add one parity bit after the data bits when 1.
REQ-008 parity_odd  input  1  SHALL select odd parity when 1 and even parity when 0; it is ignored when parity_en=0.
REQ-009 rx_data  output  DATA_BITS  SHALL be the received byte held in the output register.
REQ-010 rx_valid  output  1  SHALL indicate that rx_data holds an unconsumed frame.
REQ-011 rx_ready  input  1  SHALL be the consumer accept; a transfer occurs on any clk with rx_valid & rx_ready.
REQ-012 frame_err, parity_err, overrun_err  output  1 each  SHALL be one-clk error pulses.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before use; all references to rx below mean the synchronized rx.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- The FSM and its tick counter SHALL advance only on clk cycles with Bclk=1.
REQ-015 IDLE: rx=0 on a tick SHALL move the FSM to START and clear the tick counter.
REQ-016 START: after OVERSAMPLE/2-1 further ticks (mid-bit), rx is sampled.
- rx=0 SHALL move the FSM to DATA.
- rx=1 is a false start and SHALL return the FSM to IDLE with no outputs.
REQ-017 DATA: one bit SHALL be sampled every OVERSAMPLE ticks and shifted in LSB-first.
- After DATA_BITS samples the FSM SHALL move to PARITY if parity_en=1, else to STOP.
REQ-018 PARITY: the sample SHALL be compared with the XOR of the data bits, inverted when parity_odd=1; a mismatch SHALL set an internal parity-fail flag.
REQ-019 STOP: the stop bit SHALL be sampled OVERSAMPLE ticks after the previous sample, and the FSM SHALL return to IDLE on that same tick.
REQ-020 Stop sample 0 SHALL pulse frame_err on the following clk; the data SHALL be discarded and rx_valid SHALL NOT assert.
REQ-021 A parity fail with a good stop bit SHALL pulse parity_err on the following clk; the data SHALL be discarded.
REQ-022 A good frame with rx_valid=0, or with rx_valid=1 and rx_ready=1 on the same clk, SHALL load rx_data and set rx_valid on the clk after the stop-sample clk.
REQ-023 A good frame with rx_valid=1 and rx_ready=0 SHALL drop the new data, pulse overrun_err, and leave rx_data and rx_valid unchanged.
REQ-024 rx_valid SHALL stay high until a handshake, then clear on the next clk unless REQ-022 reloads it on that same clk.
REQ-025 The tick counter SHALL be $clog2(OVERSAMPLE) bits and wrap to 0 at each sample point.
- The bit counter SHALL be $clog2(DATA_BITS+1) bits.
REQ-026 parity_en and parity_odd SHALL be sampled on leaving IDLE; changes mid-frame SHALL have no effect on the current frame.

Reset
REQ-027 While reset_n=0 at a clk edge:
- FSM SHALL be IDLE and all counters and the shift register 0.
- rx_data SHALL be 0; rx_valid, frame_err, parity_err and overrun_err SHALL be 0.
- Synchronizer flops SHALL be 1.
REQ-028 Reset mid-frame SHALL abandon the frame without any output pulse; reception SHALL resume with the next falling edge after reset_n=1.

Structure
REQ-029 The uart_pkg package SHALL hold the rx_state_t enum and the default DATA_BITS/OVERSAMPLE constants.
REQ-030 The synchronizer SHALL be the sub-module uart_sync2, reset value 1.

Verification
REQ-031 0xA5, 8N1, Bclk every 27 clk -> rx_valid=1 with rx_data=0xA5; no error pulse.
REQ-032 0x3C, parity_en=1, parity_odd=0, parity bit 0 -> rx_data=0x3C; then the same frame with parity bit 1 -> parity_err pulse, rx_valid stays 0.
REQ-033 rx low for 4 ticks only -> FSM returns to IDLE; no rx_valid and no error pulse.
REQ-034 0x55 with stop bit 0 -> frame_err pulse, rx_valid stays 0, then next frame 0x12 is received correctly.
REQ-035 Frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11 held, overrun_err pulses once; handshake then clears rx_valid.
REQ-036 reset_n=0 during data bit 3 of 0xFF -> all outputs 0; the following frame 0x81 is received correctly.
